// File: rtl/alu_pkg.sv
// Types shared by the ALU, the issue controller and its response FIFO.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 6;
    localparam int unsigned ALU_TAG_W = 2;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } operation_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] data;
        logic [ALU_TAG_W-1:0] tag;
        operation_t           op;
    } alu_rsp_t;

endpackage

// File: rtl/alu2.sv
// Registered two-stage ALU: inputs captured on one edge, result on the next.
// No backpressure; out_valid is tied high and carries no information.
module alu2
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  operation_t       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    operation_t       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;

    always_comb begin
        op_d = in_valid ? op_in : OP_NOP;
        a_d  = in_valid ? a_in : '0;
        b_d  = in_valid ? b_in : '0;
        case (op_q)
            OP_ADD:  out_d = a_q + b_q;
            OP_SUB:  out_d = a_q - b_q;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= OP_NOP;
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
        end else begin
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
        end
    end

    assign out       = out_q;
    assign out_valid = 1'b1;

endmodule

// File: rtl/alu_rsp_fifo.sv
// In-order response buffer with synchronous reset; pointers wrap mod DEPTH.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = alu_rsp_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues tagged commands into the fixed-latency ALU, tracks them with a delay line
// and buffers results in order; credits cap in-flight work at the FIFO depth.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = ALU_WIDTH,
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = ALU_TAG_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  operation_t                   cmd_op,
    input  logic [WIDTH-1:0]             cmd_a,
    input  logic [WIDTH-1:0]             cmd_b,
    input  logic [TAG_W-1:0]             cmd_tag,
    output operation_t                   alu_op,
    output logic [WIDTH-1:0]             alu_a,
    output logic [WIDTH-1:0]             alu_b,
    output logic                         alu_in_valid,
    input  logic [WIDTH-1:0]             alu_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH-1:0]             rsp_data,
    output logic [TAG_W-1:0]             rsp_tag,
    output operation_t                   rsp_op,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned DL_N  = ALU_LAT + 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        operation_t       op;
    } stage_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        operation_t       op;
    } rsp_t;

    operation_t             alu_op_q, alu_op_d;
    logic [WIDTH-1:0]       alu_a_q, alu_a_d;
    logic [WIDTH-1:0]       alu_b_q, alu_b_d;
    logic                   alu_in_valid_q, alu_in_valid_d;
    stage_t [DL_N-1:0]      dl_q, dl_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;

    logic accept, pop, push;
    logic fifo_full, fifo_empty;
    rsp_t push_entry, head;

    assign cmd_ready  = (outstanding_q < CNT_W'(DEPTH));
    assign accept     = cmd_valid && cmd_ready;
    assign rsp_valid  = !fifo_empty;
    assign pop        = rsp_valid && rsp_ready;
    assign push       = dl_q[DL_N-1].valid;
    assign push_entry = rsp_t'{data: alu_out, tag: dl_q[DL_N-1].tag, op: dl_q[DL_N-1].op};

    always_comb begin
        alu_in_valid_d = accept;
        alu_op_d       = accept ? cmd_op : OP_NOP;
        alu_a_d        = accept ? cmd_a : '0;
        alu_b_d        = accept ? cmd_b : '0;
        // Stage 0 loads alongside the issue regs, so the last stage lines up with alu_out.
        dl_d[0] = accept ? stage_t'{valid: 1'b1, tag: cmd_tag, op: cmd_op} : '0;
        for (int unsigned i = 1; i < DL_N; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        outstanding_d = outstanding_q;
        if (accept && !pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!accept && pop) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in_valid_q <= 1'b0;
            alu_op_q       <= OP_NOP;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            dl_q           <= '0;
            outstanding_q  <= '0;
        end else begin
            alu_in_valid_q <= alu_in_valid_d;
            alu_op_q       <= alu_op_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            dl_q           <= dl_d;
            outstanding_q  <= outstanding_d;
        end
    end

    alu_rsp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (rsp_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign alu_in_valid = alu_in_valid_q;
    assign alu_op       = alu_op_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign rsp_data     = head.data;
    assign rsp_tag      = head.tag;
    assign rsp_op       = head.op;
    assign outstanding  = outstanding_q;

    a_cmd_stable: assert property (@(posedge clk) disable iff (rst)
        (cmd_valid && !cmd_ready) |=> (cmd_valid && $stable(cmd_op) && $stable(cmd_a)
                                       && $stable(cmd_b) && $stable(cmd_tag)));
    a_credit_cap: assert property (@(posedge clk) disable iff (rst)
        outstanding_q <= CNT_W'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl driving a real alu2: directed vectors, multi-cycle corner
// sequences and random traffic, all checked against a transaction-level scoreboard.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    operation_t cmd_op;
    logic [5:0] cmd_a, cmd_b;
    logic [1:0] cmd_tag;
    operation_t alu_op;
    logic [5:0] alu_a, alu_b;
    logic       alu_in_valid;
    logic [5:0] alu_out;
    logic       alu_out_valid;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_data;
    logic [1:0] rsp_tag;
    operation_t rsp_op;
    logic [2:0] outstanding;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(6), .ALU_LAT(2), .DEPTH(DEPTH), .TAG_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_in_valid (alu_in_valid),
        .alu_out      (alu_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_op       (rsp_op),
        .outstanding  (outstanding)
    );

    alu2 #(.WIDTH(6)) u_alu (
        .clk       (clk),
        .rst       (rst),
        .op_in     (alu_op),
        .a_in      (alu_a),
        .b_in      (alu_b),
        .in_valid  (alu_in_valid),
        .out       (alu_out),
        .out_valid (alu_out_valid)
    );

    // Scoreboard: each accepted command becomes visible at a known cycle index.
    typedef struct {
        logic [5:0] data;
        logic [1:0] tag;
        operation_t op;
        int         avail;
    } exp_t;

    typedef struct {
        operation_t op;
        logic [5:0] a;
        logic [5:0] b;
        logic [1:0] tag;
        logic [5:0] want;
    } vec_t;

    exp_t       m_q[$];
    int         m_out;
    logic       m_alu_v;
    operation_t m_alu_op;
    logic [5:0] m_alu_a, m_alu_b;
    int         cyc;
    logic [5:0] log_data[$];
    logic [1:0] log_tag[$];
    int         n_total = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [5:0] ref_alu(operation_t op, logic [5:0] a, logic [5:0] b);
        int r;
        case (op)
            OP_ADD:  r = (int'(a) + int'(b)) % 64;
            OP_SUB:  r = (int'(a) - int'(b) + 64) % 64;
            default: r = 0;
        endcase
        return r[5:0];
    endfunction

    function automatic bit head_ready();
        return (m_q.size() > 0) && (m_q[0].avail <= cyc);
    endfunction

    task automatic check_outputs();
        chk("cmd_ready", cmd_ready, m_out < DEPTH);
        chk("outstanding", outstanding, m_out);
        chk("alu_in_valid", alu_in_valid, m_alu_v);
        chk("alu_op", alu_op, m_alu_op);
        chk("alu_a", alu_a, m_alu_a);
        chk("alu_b", alu_b, m_alu_b);
        chk("rsp_valid", rsp_valid, head_ready());
        if (head_ready()) begin
            chk("rsp_data", rsp_data, m_q[0].data);
            chk("rsp_tag", rsp_tag, m_q[0].tag);
            chk("rsp_op", rsp_op, m_q[0].op);
        end
    endtask

    // Called at a negedge: check, drive, advance model, then move to the next negedge.
    task automatic cycle(input logic v, input operation_t op, input logic [5:0] a,
                         input logic [5:0] b, input logic [1:0] tag, input logic rr,
                         output logic acc);
        logic pop_m;
        exp_t e;
        check_outputs();
        cmd_valid = v;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        rsp_ready = rr;
        acc   = v && (m_out < DEPTH);
        pop_m = rr && head_ready();
        if (pop_m) begin
            log_data.push_back(rsp_data);
            log_tag.push_back(rsp_tag);
            e = m_q.pop_front();
        end
        if (acc) begin
            e.data  = ref_alu(op, a, b);
            e.tag   = tag;
            e.op    = op;
            e.avail = cyc + 4;
            m_q.push_back(e);
        end
        m_out    = m_out + int'(acc) - int'(pop_m);
        m_alu_v  = acc;
        m_alu_op = acc ? op : OP_NOP;
        m_alu_a  = acc ? a : 6'd0;
        m_alu_b  = acc ? b : 6'd0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input operation_t op, input logic [5:0] a, input logic [5:0] b,
                        input logic [1:0] tag, input logic rr);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            cycle(1'b1, op, a, b, tag, rr, acc);
            n++;
        end
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        repeat (n) cycle(1'b0, OP_NOP, 6'd0, 6'd0, 2'd0, rr, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_q.size() > 0 && n < 60) begin
            idle(1, 1'b1);
            n++;
        end
    endtask

    task automatic do_reset(input int edges);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;
        repeat (edges) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_out    = 0;
        m_alu_v  = 1'b0;
        m_alu_op = OP_NOP;
        m_alu_a  = '0;
        m_alu_b  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[4];
        int         n;
        logic       acc;
        logic       pend;
        operation_t p_op;
        logic [5:0] p_a, p_b;
        logic [1:0] p_tag;

        vecs[0] = '{OP_ADD, 6'd5,  6'd3, 2'd1, 6'd8};
        vecs[1] = '{OP_SUB, 6'd2,  6'd5, 2'd2, 6'd61};
        vecs[2] = '{OP_ADD, 6'd63, 6'd1, 2'd3, 6'd0};
        vecs[3] = '{OP_NOP, 6'd7,  6'd7, 2'd0, 6'd0};

        cyc = 0;
        do_reset(2);

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu_in_valid", alu_in_valid, 0);
        chk("rst_alu_op", alu_op, OP_NOP);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_op", rsp_op, OP_NOP);
        chk("rst_outstanding", outstanding, 0);
        chk("alu_out_valid", alu_out_valid, 1);

        // Directed single commands: value, tag and accept-to-valid latency.
        for (int i = 0; i < 4; i++) begin
            log_data.delete();
            log_tag.delete();
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1);
            n = 0;
            while (!rsp_valid && n < 8) begin
                idle(1, 1'b1);
                n++;
            end
            chk("vec_latency", n, 3);
            idle(2, 1'b1);
            chk("vec_count", log_data.size(), 1);
            if (log_data.size() > 0) begin
                chk("vec_data", log_data[0], vecs[i].want);
                chk("vec_tag", log_tag[0], vecs[i].tag);
            end
        end

        // Backpressure: four fill the credits, the fifth waits until the first pop.
        log_data.delete();
        log_tag.delete();
        for (int t = 0; t < 4; t++) send(OP_ADD, 6'(t), 6'd10, 2'(t), 1'b0);
        repeat (3) cycle(1'b1, OP_ADD, 6'd4, 6'd10, 2'd0, 1'b0, acc);
        chk("full_outstanding", outstanding, 4);
        chk("full_cmd_ready", cmd_ready, 0);
        send(OP_ADD, 6'd4, 6'd10, 2'd0, 1'b1);
        send(OP_ADD, 6'd5, 6'd10, 2'd1, 1'b1);
        drain();
        chk("bp_count", log_data.size(), 6);
        for (int t = 0; t < 6 && t < log_data.size(); t++) begin
            chk("bp_data", log_data[t], t + 10);
            chk("bp_tag", log_tag[t], t % 4);
        end

        // Back-to-back adds with the consumer always ready.
        log_data.delete();
        log_tag.delete();
        for (int i = 0; i < 16; i++) send(OP_ADD, 6'(i), 6'(i), 2'(i % 4), 1'b1);
        drain();
        chk("stream_count", log_data.size(), 16);
        for (int i = 0; i < 16 && i < log_data.size(); i++) begin
            chk("stream_data", log_data[i], (2 * i) % 64);
        end

        // From a full FIFO, keep issuing while popping every cycle.
        log_data.delete();
        log_tag.delete();
        for (int t = 0; t < 4; t++) send(OP_SUB, 6'(20 + t), 6'(t), 2'(t), 1'b0);
        idle(3, 1'b0);
        chk("fs_outstanding", outstanding, 4);
        for (int t = 4; t < 12; t++) send(OP_SUB, 6'(20 + t), 6'(t), 2'(t % 4), 1'b1);
        drain();
        chk("fs_count", log_data.size(), 12);
        for (int t = 0; t < 12 && t < log_data.size(); t++) begin
            chk("fs_data", log_data[t], 20);
            chk("fs_tag", log_tag[t], t % 4);
        end

        // Random traffic; an offered command is held until it is accepted.
        pend  = 1'b0;
        p_op  = OP_NOP;
        p_a   = '0;
        p_b   = '0;
        p_tag = '0;
        for (int c = 0; c < 300; c++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend  = 1'b1;
                p_op  = operation_t'($urandom_range(0, 2));
                p_a   = 6'($urandom);
                p_b   = 6'($urandom);
                p_tag = 2'($urandom);
            end
            cycle(pend, p_op, p_a, p_b, p_tag, $urandom_range(0, 3) != 0, acc);
            if (acc) pend = 1'b0;
        end
        if (pend) send(p_op, p_a, p_b, p_tag, 1'b1);
        drain();
        idle(2, 1'b1);

        // Reset with three commands in flight discards all of them.
        for (int t = 0; t < 3; t++) send(OP_ADD, 6'(t), 6'd1, 2'(t), 1'b0);
        do_reset(1);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        idle(6, 1'b1);
        chk("post_rst_rsp_valid", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
